// File: rtl/clock_monitor_pkg.sv
// Clock monitor shared types, default constants and verdict helper.
// Counts are compared in 17-bit signed arithmetic so no underflow occurs.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_REPORT  = 2'd2
  } state_e;

  localparam int unsigned WINDOW_D  = 1000;
  localparam int unsigned DUT_EXP_D = 250;
  localparam int unsigned ADC_EXP_D = 100;
  localparam int unsigned TOL_D     = 1;
  localparam int unsigned DUT_PER_D = 4;
  localparam int unsigned ADC_PER_D = 10;

  function automatic logic in_tol(
    input logic [15:0] cnt,
    input logic [15:0] expv,
    input logic [15:0] tol
  );
    logic signed [16:0] d;
    logic signed [16:0] t;
    d = $signed({1'b0, cnt}) - $signed({1'b0, expv});
    t = $signed({1'b0, tol});
    return (d <= t) && (d >= -t);
  endfunction

endpackage

// File: rtl/clock_monitor_edge.sv
// One monitored clock: synchronizer, rising-edge detect, edge count
// and sticky period check between consecutive in-window edges.
module clk_edge_channel #(
  parameter int unsigned PER = 4
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_mon,
  output logic [15:0] o_count,
  output logic        o_per_err
);

  localparam logic [7:0] LP_PER_M1 = 8'(PER - 1);

  logic [1:0]  r_sync;
  logic        r_prev;
  logic [15:0] r_count;
  logic [7:0]  r_per;
  logic        r_armed;
  logic        r_err;
  logic        w_edge;

  assign w_edge = r_sync[1] & ~r_prev;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_count <= '0;
      r_per   <= '0;
      r_armed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_mon};
      r_prev <= r_sync[1];
      if (i_clr) begin
        r_count <= '0;
        r_per   <= '0;
        r_armed <= 1'b0;
        r_err   <= 1'b0;
      end else if (i_en) begin
        if (w_edge) begin
          if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
          // r_per holds gap-1 here; first edge only arms
          if (r_armed && (r_per != LP_PER_M1)) r_err <= 1'b1;
          r_per   <= '0;
          r_armed <= 1'b1;
        end else if (r_per != 8'hFF) begin
          r_per <= r_per + 8'd1;
        end
      end
    end
  end

  assign o_count   = r_count;
  assign o_per_err = r_err;

endmodule

// File: rtl/clock_monitor.sv
// Measures edge counts and periods of two slow clocks over a fixed
// gate of clk_in cycles and reports per-channel pass/stuck verdicts.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned WINDOW  = WINDOW_D,
  parameter int unsigned DUT_EXP = DUT_EXP_D,
  parameter int unsigned ADC_EXP = ADC_EXP_D,
  parameter int unsigned TOL     = TOL_D,
  parameter int unsigned DUT_PER = DUT_PER_D,
  parameter int unsigned ADC_PER = ADC_PER_D
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dut_clk,
  input  logic        adc_clk,
  output logic        busy,
  output logic        done,
  output logic [15:0] dut_count,
  output logic [15:0] adc_count,
  output logic        dut_ok,
  output logic        adc_ok,
  output logic        dut_stuck,
  output logic        adc_stuck,
  output logic        dut_per_err,
  output logic        adc_per_err
);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_win;
  logic        w_meas;
  logic        w_clr;
  logic [15:0] w_dut_cnt;
  logic [15:0] w_adc_cnt;
  logic        w_dut_err;
  logic        w_adc_err;
  logic        r_done;
  logic [15:0] r_dut_cnt;
  logic [15:0] r_adc_cnt;
  logic [1:0]  r_ok;
  logic [1:0]  r_stuck;
  logic [1:0]  r_err;

  assign w_meas = (r_state == S_MEASURE);
  assign w_clr  = (r_state == S_IDLE) && start;

  clk_edge_channel #(.PER(DUT_PER)) u_dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_meas),
    .i_mon     (dut_clk),
    .o_count   (w_dut_cnt),
    .o_per_err (w_dut_err)
  );

  clk_edge_channel #(.PER(ADC_PER)) u_adc (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_en      (w_meas),
    .i_mon     (adc_clk),
    .o_count   (w_adc_cnt),
    .o_per_err (w_adc_err)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_MEASURE;
      S_MEASURE: if (r_win == 16'd0) w_next = S_REPORT;
      S_REPORT:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_done    <= 1'b0;
      r_dut_cnt <= '0;
      r_adc_cnt <= '0;
      r_ok      <= '0;
      r_stuck   <= '0;
      r_err     <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_REPORT);
      if (w_clr) begin
        r_win <= 16'(WINDOW - 1);
      end else if (w_meas && (r_win != 16'd0)) begin
        r_win <= r_win - 16'd1;
      end
      if (r_state == S_REPORT) begin
        r_dut_cnt <= w_dut_cnt;
        r_adc_cnt <= w_adc_cnt;
        r_ok[0] <= in_tol(w_dut_cnt, 16'(DUT_EXP), 16'(TOL)) & ~w_dut_err;
        r_ok[1] <= in_tol(w_adc_cnt, 16'(ADC_EXP), 16'(TOL)) & ~w_adc_err;
        r_stuck <= {w_adc_cnt == 16'd0, w_dut_cnt == 16'd0};
        r_err   <= {w_adc_err, w_dut_err};
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign dut_count   = r_dut_cnt;
  assign adc_count   = r_adc_cnt;
  assign dut_ok      = r_ok[0];
  assign adc_ok      = r_ok[1];
  assign dut_stuck   = r_stuck[0];
  assign adc_stuck   = r_stuck[1];
  assign dut_per_err = r_err[0];
  assign adc_per_err = r_err[1];

endmodule
